stream_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that merges the 32-bit stb/ack output streams of up to four `main_N` processes onto a single shared output channel, such as `output_rs232_tx`. It sits in `user_design` between the process instances and the top-level output port. It tags each forwarded word with its source index. A watchdog raises `exception` if the downstream consumer stalls; that signal is ORed into the top-level `exception` with the process exceptions.

---
 rtl/stream_arbiter_4.sv | 147 ++++++++++++++
 tb/tb_stream_arbiter_4.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter_4.sv
// Four-requester round-robin arbiter merging stb/ack word streams onto one output
// channel, tagging each word with its source index, with a stall watchdog.
module stream_arbiter_4 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_in_0,
  input  logic             input_in_0_stb,
  output logic             input_in_0_ack,
  input  logic [WIDTH-1:0] input_in_1,
  input  logic             input_in_1_stb,
  output logic             input_in_1_ack,
  input  logic [WIDTH-1:0] input_in_2,
  input  logic             input_in_2_stb,
  output logic             input_in_2_ack,
  input  logic [WIDTH-1:0] input_in_3,
  input  logic             input_in_3_stb,
  output logic             input_in_3_ack,
  output logic [WIDTH-1:0] output_out,
  output logic             output_out_stb,
  input  logic             output_out_ack,
  output logic [1:0]       output_source,
  output logic             exception,
  output logic [1:0]       state_dbg
);

  // Handshake: on every channel a word moves on the rising edge where stb and
  // ack are both high; stb is held with data stable until that edge.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [1:0]       src_q, src_n;
  logic [3:0]       ack_q, ack_n;
  logic             out_stb_q, out_stb_n;
  logic [1:0]       last_q, last_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             exc_q, exc_n;

  logic [3:0]       stb_vec;
  logic [WIDTH-1:0] data_vec [4];
  logic             found;
  logic [1:0]       win;
  logic [1:0]       cand;

  assign stb_vec     = {input_in_3_stb, input_in_2_stb, input_in_1_stb, input_in_0_stb};
  assign data_vec[0] = input_in_0;
  assign data_vec[1] = input_in_1;
  assign data_vec[2] = input_in_2;
  assign data_vec[3] = input_in_3;

  // Search starts one past the last served requester; i=4 wraps back to last.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && stb_vec[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = data_q;
    src_n     = src_q;
    ack_n     = 4'b0000;
    out_stb_n = out_stb_q;
    last_n    = last_q;
    cnt_n     = cnt_q;
    exc_n     = exc_q;
    case (state)
      IDLE: begin
        if (found) begin
          data_n     = data_vec[win];
          src_n      = win;
          ack_n[win] = 1'b1;
          state_n    = ACK;
        end
      end
      ACK: begin
        out_stb_n = 1'b1;
        cnt_n     = '0;
        state_n   = SEND;
      end
      SEND: begin
        if (output_out_ack) begin
          out_stb_n = 1'b0;
          last_n    = src_q;
          state_n   = IDLE;
        end else if (WD_EN && (cnt_q != TO_C)) begin
          // Saturating stall counter; the flag is sticky until reset.
          cnt_n = cnt_q + CW'(1);
          if (cnt_n == TO_C) exc_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      src_q     <= 2'd0;
      ack_q     <= 4'b0000;
      out_stb_q <= 1'b0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      exc_q     <= 1'b0;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      src_q     <= src_n;
      ack_q     <= ack_n;
      out_stb_q <= out_stb_n;
      last_q    <= last_n;
      cnt_q     <= cnt_n;
      exc_q     <= exc_n;
    end
  end

  assign input_in_0_ack = ack_q[0];
  assign input_in_1_ack = ack_q[1];
  assign input_in_2_ack = ack_q[2];
  assign input_in_3_ack = ack_q[3];
  assign output_out     = data_q;
  assign output_out_stb = out_stb_q;
  assign output_source  = src_q;
  assign exception      = exc_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_stream_arbiter_4.sv
// Directed bench for stream_arbiter_4: scoreboard queue of {source, word} checked by
// a negedge monitor, plus inline timing checks and a second instance for the watchdog.
module tb_stream_arbiter_4;

  logic        clk;
  logic        rst;
  logic [31:0] in_data [4];
  logic [3:0]  in_stb;
  logic [3:0]  in_ack;
  logic [31:0] out_data;
  logic        out_stb;
  logic        out_ack;
  logic [1:0]  out_src;
  logic        exc;
  logic [1:0]  state_dbg;

  logic        w_rst;
  logic [31:0] w_data [4];
  logic [3:0]  w_stb;
  logic [3:0]  w_ack;
  logic [31:0] w_out;
  logic        w_out_stb;
  logic        w_out_ack;
  logic [1:0]  w_src;
  logic        w_exc;
  logic [1:0]  w_state;

  logic [33:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          auto_drop = 1'b1;
  bit          rate_chk = 1'b0;
  int          rate_prev = -1;

  stream_arbiter_4 #(.WIDTH(32), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .input_in_0(in_data[0]), .input_in_0_stb(in_stb[0]), .input_in_0_ack(in_ack[0]),
    .input_in_1(in_data[1]), .input_in_1_stb(in_stb[1]), .input_in_1_ack(in_ack[1]),
    .input_in_2(in_data[2]), .input_in_2_stb(in_stb[2]), .input_in_2_ack(in_ack[2]),
    .input_in_3(in_data[3]), .input_in_3_stb(in_stb[3]), .input_in_3_ack(in_ack[3]),
    .output_out(out_data), .output_out_stb(out_stb), .output_out_ack(out_ack),
    .output_source(out_src), .exception(exc), .state_dbg(state_dbg)
  );

  stream_arbiter_4 #(.WIDTH(32), .TIMEOUT(8)) u_wd (
    .clk(clk), .rst(w_rst),
    .input_in_0(w_data[0]), .input_in_0_stb(w_stb[0]), .input_in_0_ack(w_ack[0]),
    .input_in_1(w_data[1]), .input_in_1_stb(w_stb[1]), .input_in_1_ack(w_ack[1]),
    .input_in_2(w_data[2]), .input_in_2_stb(w_stb[2]), .input_in_2_ack(w_ack[2]),
    .input_in_3(w_data[3]), .input_in_3_stb(w_stb[3]), .input_in_3_ack(w_ack[3]),
    .output_out(w_out), .output_out_stb(w_out_stb), .output_out_ack(w_out_ack),
    .output_source(w_src), .exception(w_exc), .state_dbg(w_state)
  );

  // Clock and global time bound
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; requesters release stb after their ack cycle.
  task automatic tick();
    logic [3:0] acked;
    acked = in_ack;
    @(posedge clk);
    #1;
    if (auto_drop) in_stb = in_stb & ~acked;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_stb = 4'b0000;
    out_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        check("ack_onehot", 64'($countones(in_ack) <= 1), 64'd1);
        if (out_stb && out_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", {30'd0, out_src, out_data}, 64'h3_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_word", {30'd0, out_src, out_data}, {30'd0, e});
          end
          if (rate_chk) begin
            if (rate_prev >= 0) check("word_gap", 64'(cyc - rate_prev), 64'd3);
            rate_prev = cyc;
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; out_ack = 1'b0; in_stb = 4'b0000;
    w_rst = 1'b1; w_out_ack = 1'b0; w_stb = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_data[k] = 32'd0;
      w_data[k] = 32'd0;
    end

    // Reset state
    reset_dut();
    check("rst_out_stb", 64'(out_stb), 64'd0);
    check("rst_out", 64'(out_data), 64'd0);
    check("rst_src", 64'(out_src), 64'd0);
    check("rst_acks", 64'(in_ack), 64'd0);
    check("rst_exc", 64'(exc), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);

    // Single request from requester 2
    in_data[2] = 32'h0000_0041; in_stb[2] = 1'b1; out_ack = 1'b1;
    exp_q.push_back({2'd2, 32'h41});
    tick();
    check("t1_ack_c1", 64'(in_ack), 64'b0100);
    check("t1_stb_c1", 64'(out_stb), 64'd0);
    tick();
    check("t1_ack_c2", 64'(in_ack), 64'd0);
    check("t1_stb_c2", 64'(out_stb), 64'd1);
    check("t1_out_c2", 64'(out_data), 64'h41);
    check("t1_src_c2", 64'(out_src), 64'd2);
    tick();
    check("t1_stb_c3", 64'(out_stb), 64'd0);
    tick();

    // All four requesters continuously active
    reset_dut();
    out_ack = 1'b1;
    auto_drop = 1'b0;
    for (int k = 0; k < 4; k++) in_data[k] = 32'hA0 + 32'(k);
    exp_q.push_back({2'd0, 32'hA0});
    exp_q.push_back({2'd1, 32'hA1});
    exp_q.push_back({2'd2, 32'hA2});
    exp_q.push_back({2'd3, 32'hA3});
    exp_q.push_back({2'd0, 32'hA0});
    rate_prev = -1; rate_chk = 1'b1;
    in_stb = 4'b1111;
    for (int i = 0; i < 13; i++) tick();
    in_stb[3:1] = 3'b000;
    tick();
    in_stb[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rate_chk = 1'b0;
    auto_drop = 1'b1;

    // Contention with last=1: requester 3 before requester 1
    in_data[1] = 32'h11; in_stb[1] = 1'b1;
    exp_q.push_back({2'd1, 32'h11});
    for (int i = 0; i < 4; i++) tick();
    in_data[1] = 32'h21; in_data[3] = 32'h33;
    in_stb[1] = 1'b1; in_stb[3] = 1'b1;
    exp_q.push_back({2'd3, 32'h33});
    exp_q.push_back({2'd1, 32'h21});
    tick();
    check("t3_first_ack", 64'(in_ack), 64'b1000);
    for (int i = 0; i < 6; i++) tick();

    // Backpressure with TIMEOUT=1024
    out_ack = 1'b0;
    in_data[0] = 32'hB0; in_stb[0] = 1'b1;
    exp_q.push_back({2'd0, 32'hB0});
    tick();
    check("t4_ack", 64'(in_ack), 64'b0001);
    tick();
    check("t4_stb", 64'(out_stb), 64'd1);
    in_data[2] = 32'hC2; in_stb[2] = 1'b1;
    exp_q.push_back({2'd2, 32'hC2});
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_stb", 64'(out_stb), 64'd1);
      check("t4_hold_word", {30'd0, out_src, out_data}, {30'd0, 2'd0, 32'hB0});
      check("t4_no_ack", 64'(in_ack), 64'd0);
      check("t4_no_exc", 64'(exc), 64'd0);
      tick();
    end
    out_ack = 1'b1;
    tick();
    check("t4_released", 64'(out_stb), 64'd0);
    for (int i = 0; i < 4; i++) tick();

    // Reset during SEND discards the latched word
    out_ack = 1'b0;
    in_data[3] = 32'h55; in_stb[3] = 1'b1;
    tick();
    tick();
    check("t6_send", {31'd0, out_stb, out_src, out_data}, {31'd1, 2'd3, 32'h55});
    rst = 1'b1;
    tick();
    check("t6_rst_stb", 64'(out_stb), 64'd0);
    check("t6_rst_out", 64'(out_data), 64'd0);
    check("t6_rst_src", 64'(out_src), 64'd0);
    check("t6_rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b0;
    out_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_replay", 64'(out_stb), 64'd0);
    end

    // After reset requester 0 has priority over 2
    in_data[0] = 32'hD0; in_data[2] = 32'hD2; in_stb = 4'b0101;
    exp_q.push_back({2'd0, 32'hD0});
    exp_q.push_back({2'd2, 32'hD2});
    for (int i = 0; i < 7; i++) tick();

    // Watchdog on the TIMEOUT=8 instance
    tick();
    w_rst = 1'b0;
    check("wd_rst_exc", 64'(w_exc), 64'd0);
    w_data[1] = 32'h77; w_stb[1] = 1'b1;
    tick();
    check("wd_ack", 64'(w_ack), 64'b0010);
    tick();
    w_stb[1] = 1'b0;
    check("wd_send", {31'd0, w_out_stb, w_src, w_out}, {31'd1, 2'd1, 32'h77});
    check("wd_exc0", 64'(w_exc), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("wd_exc_step", 64'(w_exc), (i == 8) ? 64'd1 : 64'd0);
      check("wd_hold_stb", 64'(w_out_stb), 64'd1);
    end
    w_out_ack = 1'b1;
    tick();
    check("wd_done_stb", 64'(w_out_stb), 64'd0);
    check("wd_sticky", 64'(w_exc), 64'd1);
    tick();
    check("wd_sticky2", 64'(w_exc), 64'd1);
    w_rst = 1'b1;
    tick();
    check("wd_cleared", 64'(w_exc), 64'd0);
    w_rst = 1'b0;

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
